// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: digit code type, active-low glyph table
// (bit 6 = segment A, 0 = lit) and the all-segments-off pattern.
package seven_segment_pkg;

  typedef logic [3:0] digit_code_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational hex code to active-low seven-segment glyph lookup.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  digit_code_t i_Code,
  output logic [6:0]  o_Segment
);

  assign o_Segment = GLYPH[i_Code];

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit common-anode driver with frame-synchronous double buffering.
// Optional leading-zero blanking: define SEVEN_SEGMENT_LZ_BLANK_EN.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 25000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  output logic [6:0]              o_Segment,
  output logic [NUM_DIGITS-1:0]   o_Digit_En_L,
  output logic                    o_Frame
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_flag;

  logic                    tc;
  logic                    wrap;
  digit_code_t             cur_code;
  logic [6:0]              glyph;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   en_next;

  assign tc       = (presc == PRESC_MAX);
  assign wrap     = tc && (idx == IDX_MAX);
  assign cur_code = display[4*idx +: 4];
  assign en_next  = ~(NUM_DIGITS'(1) << idx);

`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
  // Blank when this digit and every digit above it are zero; digit 0 always shows.
  assign blank = (idx != '0) && ((display >> (4*idx)) == '0);
`else
  assign blank = 1'b0;
`endif

  seven_segment_decode u_decode (
    .i_Code    (cur_code),
    .o_Segment (glyph)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc        <= '0;
      idx          <= '0;
      display      <= '0;
      pending      <= '0;
      pend_flag    <= 1'b0;
      o_Segment    <= SEG_OFF;
      o_Digit_En_L <= '1;
      o_Frame      <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) idx <= wrap ? '0 : idx + 1'b1;
      o_Frame <= wrap;
      if (wrap && pend_flag) begin
        display   <= pending;
        pend_flag <= 1'b0;
      end
      // A load on the boundary edge wins over the flag clear and lands in pending.
      if (i_Load) begin
        pending   <= i_Digits;
        pend_flag <= 1'b1;
      end
      o_Segment    <= blank ? SEG_OFF : glyph;
      o_Digit_En_L <= en_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (NUM_DIGITS=4, REFRESH_DIV=4)
// against a cycle-count based reference model of the display timing.
module tb_seven_segment_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_Load = 1'b0;
  logic [15:0] i_Digits = '0;
  logic [6:0]  o_Segment;
  logic [3:0]  o_Digit_En_L;
  logic        o_Frame;

  int total = 0;
  int bad = 0;

  // Reference model: edges since reset release plus the two buffers.
  int          e;
  logic [15:0] m_disp, m_pend;
  logic        m_flag;
  logic [3:0]  exp_en;
  logic [6:0]  exp_seg;
  logic        exp_frame;

  seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Load       (i_Load),
    .i_Digits     (i_Digits),
    .o_Segment    (o_Segment),
    .o_Digit_En_L (o_Digit_En_L),
    .o_Frame      (o_Frame)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [6:0] exp_glyph(input logic [15:0] disp, input int k);
    logic [15:0] upper;
    upper = disp >> (4*k);
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
    if (k > 0 && upper == 16'h0) return OFF;
`endif
    return TBL[upper[3:0]];
  endfunction

  task automatic model_reset();
    e = 0; m_disp = '0; m_pend = '0; m_flag = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, return at the next negedge.
  task automatic tick(input logic ld, input logic [15:0] d);
    int k;
    i_Load = ld; i_Digits = d;
    @(posedge i_Clk);
    e++;
    k = ((e - 1) / R) % N;
    exp_en    = ~(4'b0001 << k);
    exp_seg   = exp_glyph(m_disp, k);
    exp_frame = (e % (N*R)) == 0;
    if (exp_frame && m_flag) begin m_disp = m_pend; m_flag = 1'b0; end
    if (ld) begin m_pend = d; m_flag = 1'b1; end
    @(negedge i_Clk);
    i_Load = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    repeat (3) @(negedge i_Clk);
    total++;
    if (o_Segment !== OFF) begin bad++; $display("FAIL reset_seg got=%b want=%b", o_Segment, OFF); end
    total++;
    if (o_Digit_En_L !== 4'b1111) begin bad++; $display("FAIL reset_en got=%b want=1111", o_Digit_En_L); end
    total++;
    if (o_Frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", o_Frame); end
    model_reset();
    i_Rst_L = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 16'h0);
      total++;
      if (o_Digit_En_L !== exp_en) begin bad++; $display("FAIL free_run_en e=%0d got=%b want=%b", e, o_Digit_En_L, exp_en); end
      total++;
      if (o_Segment !== exp_seg) begin bad++; $display("FAIL free_run_seg e=%0d got=%b want=%b", e, o_Segment, exp_seg); end
      total++;
      if (o_Frame !== exp_frame) begin bad++; $display("FAIL free_run_frame e=%0d got=%b want=%b", e, o_Frame, exp_frame); end
    end
  endtask

  // Runs a list of (offset, value) loads and checks every cycle until quiet.
  task automatic test_load_seq(input string name, input int n, input int at0, input logic [15:0] v0,
                               input int at1, input logic [15:0] v1, input int run);
    for (int i = 0; i < run; i++) begin
      if (i == at0 && n > 0) tick(1'b1, v0);
      else if (i == at1 && n > 1) tick(1'b1, v1);
      else tick(1'b0, 16'h0);
      total++;
      if (o_Digit_En_L !== exp_en) begin bad++; $display("FAIL %s_en e=%0d got=%b want=%b", name, e, o_Digit_En_L, exp_en); end
      total++;
      if (o_Segment !== exp_seg) begin bad++; $display("FAIL %s_seg e=%0d got=%b want=%b", name, e, o_Segment, exp_seg); end
      total++;
      if (o_Frame !== exp_frame) begin bad++; $display("FAIL %s_frame e=%0d got=%b want=%b", name, e, o_Frame, exp_frame); end
    end
  endtask

  task automatic test_boundary_load();
    int to_edge;
    // 1111 mid-frame, then 3333 exactly on the wrap edge.
    to_edge = (N*R) - (e % (N*R));
    test_load_seq("bnd_edge", 2, 2, 16'h1111, to_edge - 1, 16'h3333, to_edge + 2*N*R);
    // 1111 mid-frame, then 3333 in the cycle o_Frame is high.
    to_edge = (N*R) - (e % (N*R));
    test_load_seq("bnd_frame", 2, 2, 16'h1111, to_edge, 16'h3333, to_edge + 2*N*R);
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic        ld;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      d  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      tick(ld, d);
      total++;
      if (o_Digit_En_L !== exp_en) begin bad++; $display("FAIL rand_en e=%0d got=%b want=%b", e, o_Digit_En_L, exp_en); end
      total++;
      if (o_Segment !== exp_seg) begin bad++; $display("FAIL rand_seg e=%0d got=%b want=%b", e, o_Segment, exp_seg); end
      total++;
      if (o_Frame !== exp_frame) begin bad++; $display("FAIL rand_frame e=%0d got=%b want=%b", e, o_Frame, exp_frame); end
    end
  endtask

  task automatic test_async_reset();
    test_load_seq("pre_rst", 1, 1, 16'hABCD, 0, 16'h0, 6);
    i_Load = 1'b1; i_Digits = 16'h5678;
    #2 i_Rst_L = 1'b0;
    #1;
    total++;
    if (o_Segment !== OFF) begin bad++; $display("FAIL async_rst_seg got=%b want=%b", o_Segment, OFF); end
    total++;
    if (o_Digit_En_L !== 4'b1111) begin bad++; $display("FAIL async_rst_en got=%b want=1111", o_Digit_En_L); end
    total++;
    if (o_Frame !== 1'b0) begin bad++; $display("FAIL async_rst_frame got=%b want=0", o_Frame); end
    i_Load = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    model_reset();
    i_Rst_L = 1'b1;
    test_load_seq("post_rst", 0, 0, 16'h0, 0, 16'h0, 2*N*R + 2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_load_seq("load_12af", 1, 2, 16'h12AF, 0, 16'h0, 40);
    test_load_seq("b2b", 2, 1, 16'h1111, 5, 16'h2222, 40);
    test_boundary_load();
    test_load_seq("lz_0050", 1, 3, 16'h0050, 0, 16'h0, 40);
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
